// File: rtl/rain_column_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rain_column_sched                                                |
// | Purpose : Per-column character table for the falling-character display,   |
// |           with a single table port shared by VGA lookup, move sweep and   |
// |           spawn. Optional macro COLUMN_WRAP_EN wraps columns instead of   |
// |           retiring them when they fall off the bottom of the screen.      |
// | Revision: 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rain_column_sched #(
  parameter int NUM_COLS = 80,
  parameter int COL_W    = 7,
  parameter int Y_W      = 9,
  parameter int SPD_W    = 4,
  parameter int SCREEN_H = 480
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [COL_W-1:0] rd_col,
  output logic             rd_valid,
  output logic             rd_active,
  output logic [7:0]       rd_ascii,
  output logic [Y_W-1:0]   rd_y,
  input  logic             move_tick,
  input  logic             spawn_req,
  input  logic [COL_W-1:0] spawn_col,
  input  logic [7:0]       spawn_ascii,
  input  logic [Y_W-1:0]   spawn_y,
  input  logic [SPD_W-1:0] spawn_speed,
  output logic             spawn_ack,
  output logic             spawn_ok,
  output logic             sweep_busy,
  output logic             tick_missed,
  output logic [COL_W:0]   active_count
);

  localparam logic [COL_W-1:0] c_last_col = COL_W'(NUM_COLS - 1);
  localparam logic [Y_W:0]     c_screen_h = (Y_W + 1)'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SW_RD = 2'd1,
    SW_WR = 2'd2
  } state_t;

  state_t             r_state;
  logic [COL_W-1:0]   r_col_ptr;

  logic               r_active [NUM_COLS];
  logic [7:0]         r_ascii  [NUM_COLS];
  logic [Y_W-1:0]     r_y      [NUM_COLS];
  logic [SPD_W-1:0]   r_speed  [NUM_COLS];

  // Entry captured in SW_RD and written back in SW_WR.
  logic               r_sw_active;
  logic [Y_W-1:0]     r_sw_y;
  logic [SPD_W-1:0]   r_sw_speed;

  logic               w_rd_hit;
  logic               w_spawn_grant;
  logic               w_spawn_reject;
  logic [Y_W:0]       w_y_sum;
  logic               w_y_over;

  assign w_rd_hit = rd_req && (rd_col <= c_last_col) && r_active[rd_col];

  // A spawn_ack high this cycle belongs to the request just consumed, so the
  // still-high spawn_req must not be granted a second time.
  assign w_spawn_grant  = spawn_req && (r_state == IDLE) && !rd_req && !move_tick && !spawn_ack;
  assign w_spawn_reject = (spawn_col > c_last_col) || ({1'b0, spawn_y} >= c_screen_h) ||
                          r_active[spawn_col];

  assign w_y_sum  = {1'b0, r_sw_y} + {{(Y_W + 1 - SPD_W){1'b0}}, r_sw_speed};
  assign w_y_over = (w_y_sum >= c_screen_h);

`ifdef COLUMN_WRAP_EN
  logic [Y_W-1:0] w_y_wrap;
  assign w_y_wrap = Y_W'(w_y_sum - c_screen_h);
`endif

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state      <= IDLE;
      r_col_ptr    <= '0;
      r_sw_active  <= 1'b0;
      r_sw_y       <= '0;
      r_sw_speed   <= '0;
      rd_valid     <= 1'b0;
      rd_active    <= 1'b0;
      rd_ascii     <= '0;
      rd_y         <= '0;
      spawn_ack    <= 1'b0;
      spawn_ok     <= 1'b0;
      sweep_busy   <= 1'b0;
      tick_missed  <= 1'b0;
      active_count <= '0;
      for (int i = 0; i < NUM_COLS; i++) r_active[i] <= 1'b0;
    end else begin
      rd_valid  <= rd_req;
      rd_active <= w_rd_hit;
      rd_ascii  <= w_rd_hit ? r_ascii[rd_col] : '0;
      rd_y      <= w_rd_hit ? r_y[rd_col] : '0;

      spawn_ack <= w_spawn_grant;
      spawn_ok  <= w_spawn_grant && !w_spawn_reject;

      if (move_tick && (r_state != IDLE)) tick_missed <= 1'b1;

      case (r_state)
        IDLE: begin
          if (move_tick) begin
            r_state    <= SW_RD;
            r_col_ptr  <= '0;
            sweep_busy <= 1'b1;
          end else if (w_spawn_grant && !w_spawn_reject) begin
            r_active[spawn_col] <= 1'b1;
            r_ascii[spawn_col]  <= spawn_ascii;
            r_y[spawn_col]      <= spawn_y;
            r_speed[spawn_col]  <= spawn_speed;
            active_count        <= active_count + (COL_W + 1)'(1);
          end
        end

        SW_RD: begin
          if (!rd_req) begin
            r_sw_active <= r_active[r_col_ptr];
            r_sw_y      <= r_y[r_col_ptr];
            r_sw_speed  <= r_speed[r_col_ptr];
            r_state     <= SW_WR;
          end
        end

        SW_WR: begin
          if (!rd_req) begin
            if (r_sw_active) begin
              if (w_y_over) begin
`ifdef COLUMN_WRAP_EN
                r_y[r_col_ptr] <= w_y_wrap;
`else
                r_active[r_col_ptr] <= 1'b0;
                active_count        <= active_count - (COL_W + 1)'(1);
`endif
              end else begin
                r_y[r_col_ptr] <= w_y_sum[Y_W-1:0];
              end
            end
            if (r_col_ptr == c_last_col) begin
              r_state    <= IDLE;
              sweep_busy <= 1'b0;
            end else begin
              r_col_ptr <= r_col_ptr + COL_W'(1);
              r_state   <= SW_RD;
            end
          end
        end

        default: begin
          r_state    <= IDLE;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rain_column_sched.sv
`default_nettype none
// Testbench for rain_column_sched: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a slot-counting table model.
module tb_rain_column_sched;

  localparam int NC = 80;
  localparam int SH = 480;

  logic       clkin = 1'b0;
  logic       rst = 1'b0;
  logic       rd_req = 1'b0;
  logic [6:0] rd_col = '0;
  logic       rd_valid, rd_active;
  logic [7:0] rd_ascii;
  logic [8:0] rd_y;
  logic       move_tick = 1'b0;
  logic       spawn_req = 1'b0;
  logic [6:0] spawn_col = '0;
  logic [7:0] spawn_ascii = '0;
  logic [8:0] spawn_y = '0;
  logic [3:0] spawn_speed = '0;
  logic       spawn_ack, spawn_ok, sweep_busy, tick_missed;
  logic [7:0] active_count;

  rain_column_sched dut (
    .clkin(clkin), .rst(rst),
    .rd_req(rd_req), .rd_col(rd_col), .rd_valid(rd_valid), .rd_active(rd_active),
    .rd_ascii(rd_ascii), .rd_y(rd_y),
    .move_tick(move_tick),
    .spawn_req(spawn_req), .spawn_col(spawn_col), .spawn_ascii(spawn_ascii),
    .spawn_y(spawn_y), .spawn_speed(spawn_speed), .spawn_ack(spawn_ack), .spawn_ok(spawn_ok),
    .sweep_busy(sweep_busy), .tick_missed(tick_missed), .active_count(active_count)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Table model: a sweep is 2*NC port slots; odd slot s updates column s/2.
  bit   m_active [0:127];
  int   m_ascii  [0:127];
  int   m_y      [0:127];
  int   m_spd    [0:127];
  bit   m_busy, m_missed;
  int   m_slot, m_count;
  bit   e_rd_valid, e_rd_active, e_ack, e_ok;
  int   e_ascii, e_y;
  bit   b0, ack0, grant;

  function automatic void apply_move(input int k);
    int ny;
    if (!m_active[k]) return;
    ny = m_y[k] + m_spd[k];
    if (ny >= SH) begin
`ifdef COLUMN_WRAP_EN
      m_y[k] = ny - SH;
`else
      m_active[k] = 0;
      m_count--;
`endif
    end else begin
      m_y[k] = ny;
    end
  endfunction

  always @(posedge clkin) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) m_active[i] = 0;
      m_busy = 0; m_missed = 0; m_slot = 0; m_count = 0;
      e_rd_valid = 0; e_rd_active = 0; e_ack = 0; e_ok = 0; e_ascii = 0; e_y = 0;
    end else begin
      b0   = m_busy;
      ack0 = e_ack;
      e_rd_valid  = rd_req;
      e_rd_active = rd_req && (rd_col < NC) && m_active[rd_col];
      if (e_rd_active) begin
        e_ascii = m_ascii[rd_col];
        e_y     = m_y[rd_col];
      end
      grant = spawn_req && !b0 && !rd_req && !move_tick && !ack0;
      e_ack = grant;
      e_ok  = grant && (spawn_col < NC) && (spawn_y < SH) && !m_active[spawn_col];
      if (e_ok) begin
        m_active[spawn_col] = 1;
        m_ascii[spawn_col]  = spawn_ascii;
        m_y[spawn_col]      = spawn_y;
        m_spd[spawn_col]    = spawn_speed;
        m_count++;
      end
      if (move_tick && b0) m_missed = 1;
      if (b0 && !rd_req) begin
        if (m_slot % 2 == 1) apply_move(m_slot / 2);
        if (m_slot == 2 * NC - 1) m_busy = 0;
        else m_slot++;
      end
      if (move_tick && !b0) begin
        m_busy = 1;
        m_slot = 0;
      end
    end
  end

  always @(negedge clkin) begin
    if (chk_en) begin
      chk("rd_valid", rd_valid, e_rd_valid);
      chk("rd_active", rd_active, e_rd_active);
      if (e_rd_active) begin
        chk("rd_ascii", rd_ascii, e_ascii);
        chk("rd_y", rd_y, e_y);
      end
      chk("spawn_ack", spawn_ack, e_ack);
      if (e_ack) chk("spawn_ok", spawn_ok, e_ok);
      chk("sweep_busy", sweep_busy, m_busy);
      chk("tick_missed", tick_missed, m_missed);
      chk("active_count", active_count, m_count);
    end
  end

  task automatic do_reset();
    rst = 1; rd_req = 0; move_tick = 0; spawn_req = 0;
    repeat (2) @(negedge clkin);
    rst = 0;
    chk_en = 1;
  endtask

  task automatic do_read(input int col, output logic act, output logic [7:0] asc, output logic [8:0] y);
    rd_req = 1; rd_col = 7'(col);
    @(negedge clkin);
    rd_req = 0;
    act = rd_active; asc = rd_ascii; y = rd_y;
  endtask

  task automatic do_spawn(input int col, input int asc, input int y, input int spd, output logic ok);
    bit seen = 0;
    ok = 0;
    spawn_req = 1; spawn_col = 7'(col); spawn_ascii = 8'(asc); spawn_y = 9'(y); spawn_speed = 4'(spd);
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clkin);
      if (spawn_ack) begin
        seen = 1;
        ok = spawn_ok;
      end
    end
    spawn_req = 0;
    if (!seen) chk("spawn_timeout", 0, 1);
  endtask

  task automatic tick_pulse();
    move_tick = 1;
    @(negedge clkin);
    move_tick = 0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (sweep_busy && cycles < 1000) begin
      cycles++;
      @(negedge clkin);
    end
    if (sweep_busy) chk("sweep_timeout", 0, 1);
  endtask

  logic       ok, act;
  logic [7:0] asc;
  logic [8:0] yy;
  int         cyc;

  initial begin
    @(negedge clkin);
    // Reset state and a single spawn/lookup.
    do_reset();
    chk("reset_count", active_count, 0);
    chk("reset_busy", sweep_busy, 0);
    do_spawn(5, 8'h41, 0, 3, ok);
    chk("spawn1_ok", ok, 1);
    chk("spawn1_count", active_count, 1);
    do_read(5, act, asc, yy);
    chk("read1_active", act, 1);
    chk("read1_ascii", asc, 8'h41);
    chk("read1_y", yy, 0);

    // Four move ticks, each sweep 160 cycles, y advances by speed.
    for (int t = 0; t < 4; t++) begin
      tick_pulse();
      wait_idle(cyc);
      chk("sweep_len", cyc, 160);
      do_read(5, act, asc, yy);
      chk("move_y", yy, 3 * (t + 1));
    end

    // Falling off the bottom.
    do_reset();
    do_spawn(5, 8'h42, 470, 15, ok);
    chk("spawn_low_ok", ok, 1);
    tick_pulse();
    wait_idle(cyc);
    do_read(5, act, asc, yy);
`ifdef COLUMN_WRAP_EN
    chk("wrap_active", act, 1);
    chk("wrap_y", yy, 5);
    chk("wrap_count", active_count, 1);
`else
    chk("retire_active", act, 0);
    chk("retire_count", active_count, 0);
`endif

    // Rejections.
    do_reset();
    do_spawn(5, 8'h43, 10, 1, ok);
    chk("rej_first_ok", ok, 1);
    do_spawn(5, 8'h44, 20, 2, ok);
    chk("rej_dup", ok, 0);
    do_spawn(80, 8'h45, 0, 2, ok);
    chk("rej_col", ok, 0);
    do_spawn(6, 8'h46, 480, 2, ok);
    chk("rej_y", ok, 0);
    chk("rej_count", active_count, 1);

    // Lookup every cycle stalls the sweep.
    move_tick = 1; rd_req = 1; rd_col = 7'd5;
    for (int n = 0; n < 300; n++) begin
      @(negedge clkin);
      move_tick = 0;
      rd_col = 7'($urandom_range(0, 85));
    end
    chk("stall_busy", sweep_busy, 1);
    rd_req = 0;
    wait_idle(cyc);
    chk("drain_len", cyc, 160);

    // Missed tick, then reset mid-sweep.
    tick_pulse();
    repeat (20) @(negedge clkin);
    tick_pulse();
    chk("tick_missed", tick_missed, 1);
    repeat (10) @(negedge clkin);
    do_reset();
    chk("rst_busy", sweep_busy, 0);
    chk("rst_count", active_count, 0);
    chk("rst_missed", tick_missed, 0);
    do_read(5, act, asc, yy);
    chk("rst_read", act, 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clkin);
      rd_req    = ($urandom_range(0, 99) < 30);
      rd_col    = 7'($urandom_range(0, 85));
      move_tick = ($urandom_range(0, 299) == 0);
      if (spawn_req && spawn_ack) begin
        spawn_req = 1'($urandom_range(0, 1));
      end else if (!spawn_req && $urandom_range(0, 3) == 0) begin
        spawn_req   = 1;
        spawn_col   = 7'($urandom_range(0, 85));
        spawn_ascii = 8'($urandom_range(0, 255));
        spawn_y     = 9'($urandom_range(0, 490));
        spawn_speed = 4'($urandom_range(0, 15));
      end
    end
    rd_req = 0; move_tick = 0; spawn_req = 0;
    repeat (3) @(negedge clkin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
